// File: rtl/input_ram_reader.sv
// Burst read controller for the image input RAM: turns a {base, length} command into
// one RAM read per cycle and returns the words on a valid/ready stream with a last marker.
module input_ram_reader #(
   parameter int ADD_SIZE  = 12,
   parameter int DATA_SIZE = 108
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [ADD_SIZE-1:0]  cmd_base_addr,
   input  logic [ADD_SIZE-1:0]  cmd_len,
   output logic                 read_en,
   output logic [ADD_SIZE-1:0]  read_address,
   input  logic [DATA_SIZE-1:0] dataIn,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_SIZE-1:0] dataOut,
   output logic                 out_last,
   output logic                 busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN
   } state_t;

   state_t                r_state;
   logic [ADD_SIZE-1:0]   r_addr;
   logic [ADD_SIZE:0]     r_remaining;
   logic                  r_inflight;
   logic                  r_inflight_last;

   logic [DATA_SIZE-1:0]  r_fifo_data [2];
   logic [1:0]            r_fifo_last;
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_count;

   logic                  w_pop;
   logic                  w_push;
   logic [2:0]            w_occ_next;
   logic                  w_issue;
   logic                  w_final_issue;

   assign w_pop  = out_valid && out_ready;
   assign w_push = r_inflight;

   // Occupancy the FIFO will have once the in-flight word lands and this cycle's pop
   // leaves; a new read is allowed only if that leaves room for the word it returns.
   assign w_occ_next    = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
   assign w_issue       = (r_state == S_ISSUE) && (r_remaining != '0) && (w_occ_next < 3'd2);
   assign w_final_issue = w_issue && (r_remaining == (ADD_SIZE+1)'(1));

   // read_en depends on out_ready in the same cycle so a full-rate stream never bubbles.
   assign read_en      = w_issue;
   assign read_address = r_addr;
   assign cmd_ready    = (r_state == S_IDLE);
   assign busy         = (r_state != S_IDLE);

   assign out_valid = (r_count != 2'd0);
   assign dataOut   = r_fifo_data[r_rd_ptr];
   assign out_last  = out_valid && r_fifo_last[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_addr          <= '0;
         r_remaining     <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         r_inflight      <= w_issue;
         r_inflight_last <= w_final_issue;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_addr      <= cmd_base_addr;
                  r_remaining <= {1'b0, cmd_len} + (ADD_SIZE+1)'(1);
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_issue) begin
                  r_addr      <= r_addr + ADD_SIZE'(1);
                  r_remaining <= r_remaining - (ADD_SIZE+1)'(1);
                  if (w_final_issue) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (w_pop && out_last) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Two-entry output FIFO; RAM data is captured the cycle after its read, unconditionally.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            r_fifo_data[i] <= '0;
         end
         r_fifo_last <= '0;
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_count     <= 2'd0;
      end else begin
         if (w_push) begin
            r_fifo_data[r_wr_ptr] <= dataIn;
            r_fifo_last[r_wr_ptr] <= r_inflight_last;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_input_ram_reader.sv
// Directed bench for input_ram_reader: table of bursts with hand-computed end points,
// plus hand-written mid-burst reset and busy-command-rejection sequences.
module tb_input_ram_reader;

   localparam int AW = 12;
   localparam int DW = 108;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_base_addr;
   logic [AW-1:0] cmd_len;
   logic          read_en;
   logic [AW-1:0] read_address;
   logic [DW-1:0] dataIn;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] dataOut;
   logic          out_last;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   input_ram_reader #(.ADD_SIZE(AW), .DATA_SIZE(DW)) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_base_addr (cmd_base_addr),
      .cmd_len       (cmd_len),
      .read_en       (read_en),
      .read_address  (read_address),
      .dataIn        (dataIn),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .dataOut       (dataOut),
      .out_last      (out_last),
      .busy          (busy)
   );

   // RAM content is the address replicated across the word so every data bit is exercised.
   function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
      return {9{a}};
   endfunction

   // One-cycle read latency; a junk value appears when no read was issued.
   always @(posedge clk) begin
      dataIn <= read_en ? word(read_address) : {96'h0, 12'hBAD};
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [AW-1:0] base;
      logic [AW-1:0] len;
      logic [15:0]   pat;        // out_ready per cycle, bit (cycle % 16)
      logic [AW-1:0] last_addr;  // address of the final read
      int            done;       // cycle of the last transfer after acceptance, 0 = unchecked
   } vec_t;

   vec_t vecs[6];

   task automatic run_burst(input vec_t v);
      int            n_rd = 0;
      int            n_out = 0;
      int            occ = 0;
      int            done_cyc = -1;
      int            first_rd = -1;
      int            first_out = -1;
      logic          infl = 1'b0;
      logic          pop;
      logic          hold = 1'b0;
      logic [DW-1:0] held_data = '0;
      logic          held_last = 1'b0;
      logic [AW-1:0] last_rd = '0;
      logic [AW-1:0] ea;
      @(negedge clk);
      cmd_base_addr = v.base;
      cmd_len       = v.len;
      cmd_valid     = 1'b1;
      out_ready     = v.pat[0];
      #1 chk("cmd_ready_idle", cmd_ready, 1'b1);
      for (int cyc = 1; cyc < 6000 && done_cyc < 0; cyc++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         out_ready = v.pat[cyc % 16];
         #1;
         if (cyc == 1) chk("busy_after_accept", busy, 1'b1);
         pop = out_valid && out_ready;
         if (hold) begin
            chk("stall_data_stable", dataOut, held_data);
            chk("stall_last_stable", out_last, held_last);
         end
         hold      = out_valid && !out_ready;
         held_data = dataOut;
         held_last = out_last;
         if (read_en) begin
            if (first_rd < 0) first_rd = cyc;
            ea = v.base + AW'(n_rd);
            chk("rd_addr", read_address, ea);
            chk("rd_credit", (occ + int'(infl) - int'(pop)) < 2, 1'b1);
            last_rd = read_address;
            n_rd++;
         end
         if (out_valid && first_out < 0) first_out = cyc;
         if (pop) begin
            chk("out_data", dataOut, word(v.base + AW'(n_out)));
            chk("out_last", out_last, n_out == int'(v.len));
            if (out_last) done_cyc = cyc;
            n_out++;
         end
         occ  = occ + int'(infl) - int'(pop);
         infl = read_en;
      end
      if (done_cyc < 0) chk("burst_timeout", 1'b0, 1'b1);
      chk("rd_count", n_rd, int'(v.len) + 1);
      chk("out_count", n_out, int'(v.len) + 1);
      chk("first_rd_cycle", first_rd, 1);
      chk("first_valid_cycle", first_out, 3);
      chk("last_rd_addr", last_rd, v.last_addr);
      if (v.done > 0) chk("done_cycle", done_cyc, v.done);
      @(negedge clk);
      #1;
      chk("busy_clear", busy, 1'b0);
      chk("cmd_ready_back", cmd_ready, 1'b1);
      chk("no_read_idle", read_en, 1'b0);
      $display("burst base=%h len=%0d words=%0d done_cycle=%0d", v.base, v.len, n_out, done_cyc);
   endtask

   initial begin
      int   n;
      logic acc;
      vec_t v;

      vecs[0] = '{base: 12'h000, len: 12'd2,    pat: 16'hFFFF, last_addr: 12'h002, done: 5};
      vecs[1] = '{base: 12'h123, len: 12'd0,    pat: 16'hFFFF, last_addr: 12'h123, done: 3};
      vecs[2] = '{base: 12'hFFE, len: 12'd3,    pat: 16'hFFFF, last_addr: 12'h001, done: 6};
      vecs[3] = '{base: 12'h010, len: 12'd7,    pat: 16'b1010_0110_1010_1001, last_addr: 12'h017, done: 0};
      vecs[4] = '{base: 12'hFF0, len: 12'd31,   pat: 16'hFFFF, last_addr: 12'h00F, done: 34};
      vecs[5] = '{base: 12'h800, len: 12'hFFF,  pat: 16'hFFFF, last_addr: 12'h7FF, done: 4098};

      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_base_addr = '0;
      cmd_len = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_read_en", read_en, 1'b0);
      chk("rst_read_address", read_address, 12'h000);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_dataOut", dataOut, {DW{1'b0}});
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_burst(vecs[i]);
      end

      // Mid-burst reset after five transfers.
      @(negedge clk);
      cmd_base_addr = 12'h000;
      cmd_len = 12'd15;
      cmd_valid = 1'b1;
      out_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 100 && n < 5; c++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         #1;
         if (out_valid && out_ready) n++;
      end
      chk("xfers_before_reset", n, 5);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_cmd_ready", cmd_ready, 1'b1);
      v = '{base: 12'h040, len: 12'd1, pat: 16'hFFFF, last_addr: 12'h041, done: 4};
      run_burst(v);

      // Command held during an active burst must wait for IDLE.
      @(negedge clk);
      cmd_base_addr = 12'h300;
      cmd_len = 12'd3;
      cmd_valid = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      cmd_base_addr = 12'h200;
      cmd_len = 12'd1;
      acc = 1'b0;
      n = 0;
      for (int c = 0; c < 50 && !acc; c++) begin
         #1;
         if (out_valid && out_ready) n++;
         if (busy) chk("busy_rejects_cmd", cmd_ready, 1'b0);
         else acc = 1'b1;
         if (!acc) @(negedge clk);
      end
      if (!acc) chk("reject_timeout", 1'b0, 1'b1);
      chk("first_burst_words", n, 4);
      chk("ready_when_idle", cmd_ready, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      chk("held_cmd_read_en", read_en, 1'b1);
      chk("held_cmd_addr", read_address, 12'h200);
      n = 0;
      for (int c = 0; c < 20 && n < 2; c++) begin
         @(negedge clk);
         #1;
         if (out_valid && out_ready) begin
            chk("held_cmd_data", dataOut, word(12'h200 + AW'(n)));
            chk("held_cmd_last", out_last, n == 1);
            n++;
         end
      end
      chk("held_cmd_words", n, 2);
      $display("held command burst words=%0d", n);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
